// File: rtl/vi_frame_gate.sv
// rtl/vi_frame_gate.sv - video frame geometry lock and whole-frame RGB565 gate
//
// Measures active pixels per line and active lines per frame of the incoming
// DVI stream. Lock is declared after a run of identical, consistent frames.
// While locked and enabled, whole frames are forwarded, packed to RGB565.
//
// Optional build macro: VI_DITHER_EN adds 2x2 ordered dither before truncation.
//
// Ports:
//   clk, rst_n        pixel clock, asynchronous active-low reset
//   enable            forwarding request, sampled at frame start only
//   in_vs, in_de      sync inputs (in_vs polarity set by VS_POL)
//   in_r, in_g, in_b  8-bit colour channels
//   out_vs, out_de    active-high vsync and gated data enable, 1-cycle latency
//   out_data          RGB565 pixel, zero when out_de is low
//   h_active          pixels per line of the last completed frame
//   v_active          lines of the last completed frame
//   locked            geometry stable
//   gate_open         the current frame is being forwarded
module vi_frame_gate #(
  parameter bit VS_POL      = 1'b1,
  parameter int LOCK_FRAMES = 3,
  parameter int CNT_W       = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             in_vs,
  input  logic             in_de,
  input  logic [7:0]       in_r,
  input  logic [7:0]       in_g,
  input  logic [7:0]       in_b,
  output logic             out_vs,
  output logic             out_de,
  output logic [15:0]      out_data,
  output logic [CNT_W-1:0] h_active,
  output logic [CNT_W-1:0] v_active,
  output logic             locked,
  output logic             gate_open
);

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    MEASURE = 2'd1,
    LOCK    = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [3:0]       LOCK_TARGET = 4'(LOCK_FRAMES - 1);

  state_t           state, state_nxt;
  logic [3:0]       match_cnt, match_nxt;

  logic             vs_q, vs_qq, de_q;
  logic             fs, le;
  logic [CNT_W-1:0] px, ln, line_len;
  logic             bad_frame;
  logic [CNT_W-1:0] ln_b, len_b;
  logic             bad_b;
  logic             frame_ok, geo_same;

  logic [7:0]       r_d, g_d, b_d;
  logic [15:0]      pix565;
  logic             fwd;
  logic             unused_rgb;

  // Frame start is the rising edge of the registered, normalised vsync; it is
  // therefore one cycle behind in_vs, in step with the 1-cycle output pipe.
  assign fs = vs_q & ~vs_qq;
  assign le = de_q & ~in_de;

  // Frame-start bookkeeping happens before any line-end in the same cycle, so
  // these are the per-frame accumulators as the line-end logic should see them.
  always_comb begin
    ln_b  = ln;
    len_b = line_len;
    bad_b = bad_frame;
    if (fs) begin
      ln_b  = '0;
      len_b = '0;
      bad_b = 1'b0;
    end
  end

  assign frame_ok = !bad_frame && (ln != '0) && (line_len != '0);
  // h_active/v_active still hold the previous frame's geometry at this FS.
  assign geo_same = (line_len == h_active) && (ln == v_active);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q      <= 1'b0;
      vs_qq     <= 1'b0;
      de_q      <= 1'b0;
      px        <= '0;
      ln        <= '0;
      line_len  <= '0;
      bad_frame <= 1'b0;
      h_active  <= '0;
      v_active  <= '0;
    end else begin
      vs_q  <= VS_POL ? in_vs : ~in_vs;
      vs_qq <= vs_q;
      de_q  <= in_de;

      if (le) begin
        px <= '0;
      end else if (in_de && (px != CNT_MAX)) begin
        px <= px + CNT_ONE;
      end

      if (fs) begin
        h_active <= line_len;
        v_active <= ln;
      end

      ln        <= ln_b;
      line_len  <= len_b;
      bad_frame <= bad_b;
      if (le) begin
        // The first line of a frame sets the reference length.
        if (ln_b == '0) begin
          line_len <= px;
        end else if (px != len_b) begin
          bad_frame <= 1'b1;
        end
        if (ln_b != CNT_MAX) begin
          ln <= ln_b + CNT_ONE;
        end
      end
    end
  end

  always_comb begin
    state_nxt = state;
    match_nxt = match_cnt;
    if (fs) begin
      case (state)
        HUNT: begin
          state_nxt = MEASURE;
          match_nxt = 4'd0;
        end
        MEASURE: begin
          if (frame_ok && geo_same) begin
            match_nxt = match_cnt + 4'd1;
          end else begin
            match_nxt = 4'd0;
          end
          if (frame_ok && (match_nxt >= LOCK_TARGET)) begin
            state_nxt = LOCK;
          end
        end
        LOCK: begin
          if (!frame_ok || !geo_same) begin
            state_nxt = MEASURE;
            match_nxt = 4'd0;
          end
        end
        default: begin
          state_nxt = HUNT;
          match_nxt = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= HUNT;
      match_cnt <= 4'd0;
      gate_open <= 1'b0;
    end else begin
      state     <= state_nxt;
      match_cnt <= match_nxt;
      // The gate only moves at frame boundaries, so frames are never cut.
      if (fs) begin
        gate_open <= (state_nxt == LOCK) && enable;
      end
    end
  end

  assign locked = (state == LOCK);

`ifdef VI_DITHER_EN
  logic [1:0] dith_idx;
  logic [2:0] rb_bias, g_bias;

  function automatic logic [7:0] sat_add(input logic [7:0] c, input logic [2:0] bias);
    logic [8:0] s;
    s = {1'b0, c} + {6'b0, bias};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  assign dith_idx = {ln_b[0], px[0]};

  always_comb begin
    rb_bias = 3'd0;
    g_bias  = 3'd0;
    case (dith_idx)
      2'd0: begin rb_bias = 3'd0; g_bias = 3'd0; end
      2'd1: begin rb_bias = 3'd4; g_bias = 3'd2; end
      2'd2: begin rb_bias = 3'd6; g_bias = 3'd3; end
      default: begin rb_bias = 3'd2; g_bias = 3'd1; end
    endcase
  end

  assign r_d = sat_add(in_r, rb_bias);
  assign g_d = sat_add(in_g, g_bias);
  assign b_d = sat_add(in_b, rb_bias);
`else
  assign r_d = in_r;
  assign g_d = in_g;
  assign b_d = in_b;
`endif

  // Low channel bits fall away in plain truncation.
  assign unused_rgb = ^{r_d[2:0], g_d[1:0], b_d[2:0]};

  assign pix565 = {r_d[7:3], g_d[7:2], b_d[7:3]};
  assign fwd    = in_de & gate_open;
  assign out_vs = vs_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_de   <= 1'b0;
      out_data <= 16'h0000;
    end else begin
      out_de   <= fwd;
      out_data <= fwd ? pix565 : 16'h0000;
    end
  end

endmodule
